// File: rtl/perf_counter_bank.sv
// Performance counter bank: nine 64-bit event counters, freeze/clear control,
// and a request/response read port with a coherent hi/lo word split.
module perf_counter_bank #(
  parameter int CNT_WIDTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exu_valid,
  input  logic        icache_start,
  input  logic        icache_isHit,
  input  logic        lsu_ren,
  input  logic        lsu_wen,
  input  logic        lsu_isWaiting,
  input  logic        branch_predict_success,
  input  logic        branch_predict_failed,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  input  logic        ctrl_wen,
  input  logic [1:0]  ctrl_wdata
);

  localparam int NUM_CNT = 9;

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_CNT-1:0]                event_vec;

  logic        freeze_q, freeze_d;
  logic        clear;
  logic        shadow_valid_q, shadow_valid_d;
  logic [31:0] shadow_hi_q, shadow_hi_d;
  logic [3:0]  shadow_idx_q, shadow_idx_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic [3:0]           rd_idx;
  logic                 rd_hi;
  logic                 rd_in_range;
  logic [CNT_WIDTH-1:0] rd_cnt;
  logic [31:0]          rd_word;
  logic                 accept;

  assign event_vec = {branch_predict_failed,
                      branch_predict_success,
                      lsu_isWaiting,
                      lsu_wen,
                      lsu_ren,
                      icache_start & icache_isHit,
                      icache_start,
                      exu_valid,
                      1'b1};

  assign clear  = ctrl_wen & ctrl_wdata[1];
  assign accept = (state_q == IDLE) & req_valid;

  assign rd_idx      = req_addr[4:1];
  assign rd_hi       = req_addr[0];
  assign rd_in_range = rd_idx < 4'(NUM_CNT);

  // Counter update: clear beats increment, freeze blocks increments.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear) begin
        cnt_d[i] = '0;
      end else if (!freeze_q && event_vec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
    freeze_d = ctrl_wen ? ctrl_wdata[0] : freeze_q;
  end

  // Read mux sees pre-update counter values; a matching shadow serves the high word.
  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_idx == 4'(i)) begin
        rd_cnt = cnt_q[i];
      end
    end
    rd_word = 32'd0;
    if (rd_in_range) begin
      if (!rd_hi) begin
        rd_word = rd_cnt[31:0];
      end else if (shadow_valid_q && (shadow_idx_q == rd_idx)) begin
        rd_word = shadow_hi_q;
      end else begin
        rd_word = rd_cnt[CNT_WIDTH-1:32];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rsp_data_d     = rsp_data_q;
    shadow_valid_d = shadow_valid_q;
    shadow_hi_d    = shadow_hi_q;
    shadow_idx_d   = shadow_idx_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d    = RESP;
          rsp_data_d = rd_word;
          if (rd_in_range && !rd_hi) begin
            shadow_valid_d = 1'b1;
            shadow_hi_d    = rd_cnt[CNT_WIDTH-1:32];
            shadow_idx_d   = rd_idx;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      shadow_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      freeze_q       <= 1'b0;
      shadow_valid_q <= 1'b0;
      shadow_hi_q    <= 32'd0;
      shadow_idx_q   <= 4'd0;
      rsp_data_q     <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      freeze_q       <= freeze_d;
      shadow_valid_q <= shadow_valid_d;
      shadow_hi_q    <= shadow_hi_d;
      shadow_idx_q   <= shadow_idx_d;
      rsp_data_q     <= rsp_data_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;

  logic unused_accept;
  assign unused_accept = accept;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a cycle model predicts read data,
// which is queued at request acceptance and compared when rsp_valid appears.
module tb_perf_counter_bank;

  localparam logic [7:0] EV_EXU  = 8'h01;
  localparam logic [7:0] EV_IC   = 8'h02;
  localparam logic [7:0] EV_HIT  = 8'h04;
  localparam logic [7:0] EV_REN  = 8'h08;
  localparam logic [7:0] EV_WEN  = 8'h10;
  localparam logic [7:0] EV_WAIT = 8'h20;
  localparam logic [7:0] EV_BPS  = 8'h40;
  localparam logic [7:0] EV_BPF  = 8'h80;

  logic        clk = 1'b0;
  logic        reset;
  logic        exu_valid, icache_start, icache_isHit, lsu_ren, lsu_wen, lsu_isWaiting;
  logic        branch_predict_success, branch_predict_failed;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [4:0]  req_addr;
  logic [31:0] rsp_data;
  logic        ctrl_wen;
  logic [1:0]  ctrl_wdata;

  int errors = 0;
  int checks = 0;

  logic [63:0] m_cnt [0:8];
  logic        m_freeze;
  logic        m_resp;
  logic        m_shv;
  logic [3:0]  m_shidx;
  logic [31:0] m_shhi;
  logic [31:0] exp_q [$];

  perf_counter_bank #(.CNT_WIDTH(64)) dut (
    .clk(clk),
    .reset(reset),
    .exu_valid(exu_valid),
    .icache_start(icache_start),
    .icache_isHit(icache_isHit),
    .lsu_ren(lsu_ren),
    .lsu_wen(lsu_wen),
    .lsu_isWaiting(lsu_isWaiting),
    .branch_predict_success(branch_predict_success),
    .branch_predict_failed(branch_predict_failed),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .ctrl_wen(ctrl_wen),
    .ctrl_wdata(ctrl_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    logic [3:0] k;
    k = a[4:1];
    if (k > 4'd8) return 32'd0;
    if (!a[0]) return m_cnt[int'(k)][31:0];
    if (m_shv && m_shidx == k) return m_shhi;
    return m_cnt[int'(k)][63:32];
  endfunction

  // Advance the model by one edge with the currently driven inputs, then the DUT.
  task automatic tick();
    logic [8:0] ev;
    logic       clr;
    if (reset) begin
      for (int i = 0; i < 9; i++) m_cnt[i] = 64'd0;
      m_freeze = 1'b0;
      m_resp   = 1'b0;
      m_shv    = 1'b0;
      m_shidx  = 4'd0;
      m_shhi   = 32'd0;
      exp_q.delete();
    end else begin
      ev = {branch_predict_failed, branch_predict_success, lsu_isWaiting, lsu_wen,
            lsu_ren, icache_start & icache_isHit, icache_start, exu_valid, 1'b1};
      if (!m_resp && req_valid) begin
        exp_q.push_back(modelRead(req_addr));
        if (req_addr[4:1] <= 4'd8 && !req_addr[0]) begin
          m_shv   = 1'b1;
          m_shidx = req_addr[4:1];
          m_shhi  = m_cnt[int'(req_addr[4:1])][63:32];
        end
        m_resp = 1'b1;
      end else if (m_resp && rsp_ready) begin
        m_resp = 1'b0;
      end
      clr = ctrl_wen && ctrl_wdata[1];
      for (int i = 0; i < 9; i++) begin
        if (clr) m_cnt[i] = 64'd0;
        else if (!m_freeze && ev[i]) m_cnt[i] = m_cnt[i] + 64'd1;
      end
      if (clr) m_shv = 1'b0;
      if (ctrl_wen) m_freeze = ctrl_wdata[0];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int n, input logic [7:0] ev);
    for (int c = 0; c < n; c++) begin
      exu_valid              = ev[0];
      icache_start           = ev[1];
      icache_isHit           = ev[2];
      lsu_ren                = ev[3];
      lsu_wen                = ev[4];
      lsu_isWaiting          = ev[5];
      branch_predict_success = ev[6];
      branch_predict_failed  = ev[7];
      tick();
    end
    {exu_valid, icache_start, icache_isHit, lsu_ren, lsu_wen, lsu_isWaiting,
     branch_predict_success, branch_predict_failed} = 8'h00;
  endtask

  task automatic ctrlWrite(input logic [1:0] w);
    ctrl_wen   = 1'b1;
    ctrl_wdata = w;
    tick();
    ctrl_wen   = 1'b0;
    ctrl_wdata = 2'b00;
  endtask

  // One read transaction; hold > 0 stalls the consumer while re-requesting.
  task automatic readCounter(input string tag, input logic [3:0] idx, input logic hi, input int hold);
    logic [31:0] exp;
    int          n;
    req_addr  = {idx, hi};
    req_valid = 1'b1;
    checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    tick();
    req_valid = (hold > 0);
    n = 0;
    while (!rsp_valid && n < 8) begin
      tick();
      n++;
    end
    checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    if (rsp_valid) begin
      exp = (exp_q.size() > 0) ? exp_q[0] : 32'hxxxx_xxxx;
      for (int h = 0; h < hold; h++) begin
        checkOutput({tag, "_held_data"}, 64'(rsp_data), 64'(exp));
        checkOutput({tag, "_held_req_ready"}, 64'(req_ready), 64'd0);
        tick();
      end
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      checkOutput({tag, "_data"}, 64'(rsp_data), 64'(exp));
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    {exu_valid, icache_start, icache_isHit, lsu_ren, lsu_wen, lsu_isWaiting,
     branch_predict_success, branch_predict_failed} = 8'h00;
    req_valid = 1'b0; req_addr = 5'd0; rsp_ready = 1'b0;
    ctrl_wen = 1'b0; ctrl_wdata = 2'b00;
    @(negedge clk);
    tick();
    tick();
    checkOutput("reset_req_ready", 64'(req_ready), 64'd1);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_rsp_data", 64'(rsp_data), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) applyStimulus(1, (i % 3 == 0) ? EV_EXU : 8'h00);
    readCounter("instret_lo", 4'd1, 1'b0, 0);
    readCounter("instret_hi", 4'd1, 1'b1, 0);
    readCounter("cycles_lo", 4'd0, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, (i == 1 || i == 4) ? (EV_IC | EV_HIT) : EV_IC);
      applyStimulus(1, 8'h00);
    end
    applyStimulus(5, EV_WAIT);
    applyStimulus(3, EV_REN);
    applyStimulus(2, EV_WEN | EV_BPS);
    applyStimulus(1, EV_BPF);
    readCounter("icache_access", 4'd2, 1'b0, 0);
    readCounter("icache_hit", 4'd3, 1'b0, 0);
    readCounter("lsu_wait", 4'd6, 1'b0, 0);
    readCounter("lsu_read", 4'd4, 1'b0, 0);
    readCounter("lsu_write", 4'd5, 1'b0, 0);
    readCounter("bp_success", 4'd7, 1'b0, 0);
    readCounter("bp_failed", 4'd8, 1'b0, 0);

    ctrlWrite(2'b01);
    applyStimulus(5, 8'hFF);
    ctrlWrite(2'b00);
    readCounter("frozen_instret", 4'd1, 1'b0, 0);
    readCounter("frozen_icache", 4'd2, 1'b0, 0);
    readCounter("frozen_bpf", 4'd8, 1'b0, 0);

    exu_valid = 1'b1;
    ctrlWrite(2'b10);
    exu_valid = 1'b0;
    readCounter("cleared_instret", 4'd1, 1'b0, 0);

    // Preload the cycle counter just below a 32-bit carry while frozen.
    ctrlWrite(2'b01);
    force dut.cnt_q = {{8{64'h0}}, 64'h0000_0000_FFFF_FFFF};
    for (int i = 0; i < 9; i++) m_cnt[i] = 64'd0;
    m_cnt[0] = 64'h0000_0000_FFFF_FFFF;
    tick();
    release dut.cnt_q;
    tick();
    readCounter("wrap_lo", 4'd0, 1'b0, 0);
    ctrlWrite(2'b00);
    applyStimulus(3, 8'h00);
    readCounter("wrap_hi_shadow", 4'd0, 1'b1, 0);
    readCounter("other_lo", 4'd1, 1'b0, 0);
    readCounter("wrap_hi_live", 4'd0, 1'b1, 0);

    readCounter("stall_hold", 4'd0, 1'b0, 4);
    readCounter("idx12_lo", 4'd12, 1'b0, 0);
    readCounter("idx12_hi", 4'd12, 1'b1, 0);

    req_addr  = 5'd2;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    checkOutput("pre_reset_rsp_valid", 64'(rsp_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("post_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("post_reset_req_ready", 64'(req_ready), 64'd1);
    readCounter("post_reset_instret", 4'd1, 1'b0, 0);
    readCounter("post_reset_lsu_wait", 4'd6, 1'b0, 0);
    readCounter("post_reset_cycles_hi", 4'd0, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
